monitor_spi_master: RTL and testbench

Host-side SPI master for the FPGA monitor link. It polls the monitor's SPI slave with fixed 56-bit frames, captures the bus snapshot (ADDR, DATA, OUTPUT_SIGNAL) and any UART byte the target sent, and returns the 4-bit INPUT_SIGNAL plus an optional UART byte to the target. It sits in the host-side FPGA/bridge logic and drives the pins that the monitor block samples.

---
 rtl/monitor_spi_pkg.sv | 41 ++++
 rtl/monitor_spi_master_sck_divider.sv | 48 ++++
 rtl/monitor_spi_master.sv | 216 +++++++++++++++++++++
 tb/tb_monitor_spi_master.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/monitor_spi_pkg.sv
// Shared frame layout, state encoding and MOSI frame builder for the
// host-side monitor SPI master.
package monitor_spi_pkg;

  localparam int MISO_BITS = 56;
  localparam int MOSI_BITS = 16;

  localparam int ADDR_LSB   = 0;
  localparam int DATA_LSB   = 24;
  localparam int OUTSIG_LSB = 40;
  localparam int RXFLAG_BIT = 44;
  localparam int RXBYTE_LSB = 48;
  localparam int TXFLAG_BIT = 4;
  localparam int TXBYTE_LSB = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP
  } state_e;

  typedef struct packed {
    logic [7:0] tx_data;
    logic [2:0] zero;
    logic       tx_flag;
    logic [3:0] insig;
  } mosi_frame_t;

  function automatic logic [MOSI_BITS-1:0] build_mosi(input logic [3:0] insig,
                                                      input logic       flag,
                                                      input logic [7:0] data);
    mosi_frame_t f;
    f.tx_data = flag ? data : 8'h00;
    f.zero    = 3'b000;
    f.tx_flag = flag;
    f.insig   = insig;
    return f;
  endfunction

endpackage

// File: rtl/monitor_spi_master_sck_divider.sv
// Half-period counter for SCK; strobes mark the last MCLK cycle of the
// high phase (fall) and of the low phase (rise).
module spi_sck_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic rise_o,
  output logic fall_o
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt_q, cnt_d;
  logic          high_q, high_d;
  logic          term;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    high_d = high_q;
    term   = en_i && (cnt_q == LAST);
    if (!en_i) begin
      // SHIFT is always entered with SCK already high.
      cnt_d  = '0;
      high_d = 1'b1;
    end else if (term) begin
      cnt_d  = '0;
      high_d = !high_q;
    end
    fall_o = term && high_q;
    rise_o = term && !high_q;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      high_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      high_q <= high_d;
    end
  end

endmodule

// File: rtl/monitor_spi_master.sv
// Host-side SPI master (mode 1) polling the monitor slave with fixed
// 56-bit frames and exchanging INPUT_SIGNAL / UART bytes with the target.
module monitor_spi_master
  import monitor_spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int SS_SETUP   = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic        MCLK_IN,
  input  logic        RUN_IN,
  input  logic        ENABLE_IN,
  input  logic [3:0]  INPUT_SIGNAL_IN,
  input  logic        TX_VALID_IN,
  input  logic [7:0]  TX_BYTE_IN,
  output logic        TX_READY,
  input  logic        SPISO_IN,
  output logic        SPICLK,
  output logic        SPISS,
  output logic        SPISI,
  output logic [23:0] ADDR,
  output logic [15:0] DATA,
  output logic [3:0]  OUTPUT_SIGNAL,
  output logic        RX_VALID,
  output logic [7:0]  RX_BYTE,
  output logic        FRAME_DONE,
  output logic        BUSY
);

  localparam int CMAX = (SS_SETUP > GAP_CYCLES) ? SS_SETUP : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [5:0]    LAST_BIT   = 6'(MISO_BITS - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [5:0]             bit_q, bit_d;
  logic                   sck_q, sck_d;
  logic                   spiss_q, spiss_d;
  logic                   spisi_q, spisi_d;
  logic [MOSI_BITS-1:0]   mosi_sr_q, mosi_sr_d;
  logic                   tx_carry_q, tx_carry_d;
  logic [MISO_BITS-1:0]   miso_sr_q, miso_sr_d;
  logic                   pending_q, pending_d;
  logic [7:0]             tx_byte_q, tx_byte_d;
  logic                   tx_ready_q, tx_ready_d;
  logic [23:0]            addr_q, addr_d;
  logic [15:0]            data_q, data_d;
  logic [3:0]             outsig_q, outsig_d;
  logic                   rx_valid_q, rx_valid_d;
  logic [7:0]             rx_byte_q, rx_byte_d;
  logic                   frame_done_q, frame_done_d;
  logic                   busy_q, busy_d;

  logic sck_rise, sck_fall, enter_setup;

  spi_sck_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk_i (MCLK_IN),
    .rst_ni(RUN_IN),
    .en_i  (state_q == SHIFT),
    .rise_o(sck_rise),
    .fall_o(sck_fall)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    sck_d        = sck_q;
    spiss_d      = spiss_q;
    spisi_d      = spisi_q;
    mosi_sr_d    = mosi_sr_q;
    tx_carry_d   = tx_carry_q;
    miso_sr_d    = miso_sr_q;
    pending_d    = pending_q;
    tx_byte_d    = tx_byte_q;
    addr_d       = addr_q;
    data_d       = data_q;
    outsig_d     = outsig_q;
    rx_byte_d    = rx_byte_q;
    rx_valid_d   = 1'b0;
    frame_done_d = 1'b0;
    enter_setup  = 1'b0;

    unique case (state_q)
      IDLE: enter_setup = ENABLE_IN;
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d   = SHIFT;
          bit_d     = '0;
          sck_d     = 1'b1;
          spisi_d   = mosi_sr_q[0];
          mosi_sr_d = mosi_sr_q >> 1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (sck_fall) begin
          sck_d     = 1'b0;
          miso_sr_d = {SPISO_IN, miso_sr_q[MISO_BITS-1:1]};
        end else if (sck_rise) begin
          if (bit_q == LAST_BIT) begin
            // Low phase of the last bit has elapsed: close the frame.
            state_d      = GAP;
            cnt_d        = '0;
            spiss_d      = 1'b0;
            spisi_d      = 1'b0;
            frame_done_d = 1'b1;
            addr_d       = miso_sr_q[ADDR_LSB +: 24];
            data_d       = miso_sr_q[DATA_LSB +: 16];
            outsig_d     = miso_sr_q[OUTSIG_LSB +: 4];
            if (miso_sr_q[RXFLAG_BIT]) begin
              rx_valid_d = 1'b1;
              rx_byte_d  = miso_sr_q[RXBYTE_LSB +: 8];
            end
            if (tx_carry_q) pending_d = 1'b0;
          end else begin
            bit_d     = bit_q + 1'b1;
            sck_d     = 1'b1;
            spisi_d   = mosi_sr_q[0];
            mosi_sr_d = mosi_sr_q >> 1;
          end
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          if (ENABLE_IN) enter_setup = 1'b1;
          else           state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The latch sees the pending flag as it was before this cycle's accept,
    // so a byte accepted on this very edge waits for the following frame.
    if (enter_setup) begin
      state_d    = SETUP;
      cnt_d      = '0;
      spiss_d    = 1'b1;
      mosi_sr_d  = build_mosi(INPUT_SIGNAL_IN, pending_q, tx_byte_q);
      tx_carry_d = pending_q;
    end

    if (TX_VALID_IN && tx_ready_q) begin
      pending_d = 1'b1;
      tx_byte_d = TX_BYTE_IN;
    end

    tx_ready_d = !pending_d;
    busy_d     = (state_d != IDLE);
  end

  // NOTE: the synchronous reset clears every register, so no partial frame or stale byte survives it.
  always_ff @(posedge MCLK_IN) begin
    if (!RUN_IN) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      sck_q        <= 1'b0;
      spiss_q      <= 1'b0;
      spisi_q      <= 1'b0;
      mosi_sr_q    <= '0;
      tx_carry_q   <= 1'b0;
      miso_sr_q    <= '0;
      pending_q    <= 1'b0;
      tx_byte_q    <= '0;
      tx_ready_q   <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      outsig_q     <= '0;
      rx_valid_q   <= 1'b0;
      rx_byte_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      sck_q        <= sck_d;
      spiss_q      <= spiss_d;
      spisi_q      <= spisi_d;
      mosi_sr_q    <= mosi_sr_d;
      tx_carry_q   <= tx_carry_d;
      miso_sr_q    <= miso_sr_d;
      pending_q    <= pending_d;
      tx_byte_q    <= tx_byte_d;
      tx_ready_q   <= tx_ready_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      outsig_q     <= outsig_d;
      rx_valid_q   <= rx_valid_d;
      rx_byte_q    <= rx_byte_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign TX_READY      = tx_ready_q;
  assign SPICLK        = sck_q;
  assign SPISS         = spiss_q;
  assign SPISI         = spisi_q;
  assign ADDR          = addr_q;
  assign DATA          = data_q;
  assign OUTPUT_SIGNAL = outsig_q;
  assign RX_VALID      = rx_valid_q;
  assign RX_BYTE       = rx_byte_q;
  assign FRAME_DONE    = frame_done_q;
  assign BUSY          = busy_q;

endmodule

// File: tb/tb_monitor_spi_master.sv
// Scoreboard bench: a mode-1 slave model serves queued MISO frames and
// captures MOSI; a monitor checks every FRAME_DONE against the expected queue.
module tb_monitor_spi_master;

  logic        mclk = 1'b0;
  logic        run_n;
  logic        enable;
  logic [3:0]  insig;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready;
  logic        spiso = 1'b0;
  logic        spiclk, spiss, spisi;
  logic [23:0] addr;
  logic [15:0] data;
  logic [3:0]  outsig;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        frame_done;
  logic        busy;

  monitor_spi_master dut (
    .MCLK_IN        (mclk),
    .RUN_IN         (run_n),
    .ENABLE_IN      (enable),
    .INPUT_SIGNAL_IN(insig),
    .TX_VALID_IN    (tx_valid),
    .TX_BYTE_IN     (tx_byte),
    .TX_READY       (tx_ready),
    .SPISO_IN       (spiso),
    .SPICLK         (spiclk),
    .SPISS          (spiss),
    .SPISI          (spisi),
    .ADDR           (addr),
    .DATA           (data),
    .OUTPUT_SIGNAL  (outsig),
    .RX_VALID       (rx_valid),
    .RX_BYTE        (rx_byte),
    .FRAME_DONE     (frame_done),
    .BUSY           (busy)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc++;

  int n_checks = 0;
  int n_errors = 0;
  int done_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [23:0] addr;
    logic [15:0] data;
    logic [3:0]  outsig;
    logic        rxv;
    logic [7:0]  rxb;
    logic [15:0] mosi;
  } exp_t;

  exp_t        exp_q[$];
  logic [55:0] slave_q[$];

  // Slave model: shifts MISO out on SCK rise, samples MOSI on SCK fall.
  logic        prev_sck = 1'b0, prev_ss = 1'b0;
  logic [55:0] s_frame = '0;
  logic [55:0] mosi_cap = '0;
  int          s_idx = 0, m_idx = 0, s_rises = 0;

  always @(negedge mclk) begin
    if (spiss && !prev_ss) begin
      s_frame  = (slave_q.size() > 0) ? slave_q.pop_front() : 56'h0;
      s_idx    = 0;
      m_idx    = 0;
      s_rises  = 0;
      mosi_cap = '0;
    end
    if (spiss && spiclk && !prev_sck) begin
      if (s_idx < 56) spiso = s_frame[s_idx];
      s_idx++;
      s_rises++;
    end
    if (spiss && !spiclk && prev_sck) begin
      if (m_idx < 56) mosi_cap[m_idx] = spisi;
      m_idx++;
    end
    prev_sck = spiclk;
    prev_ss  = spiss;
  end

  // Monitor: compares each completed frame against the scoreboard.
  exp_t e;
  always @(negedge mclk) begin
    if (run_n === 1'b1 && rx_valid === 1'b1 && frame_done !== 1'b1)
      check("rx_valid_without_frame_done", frame_done, 1'b1);
    if (run_n === 1'b1 && frame_done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_frame_done", frame_done, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("addr", addr, e.addr);
        check("data", data, e.data);
        check("output_signal", outsig, e.outsig);
        check("rx_valid", rx_valid, e.rxv);
        if (e.rxv) check("rx_byte", rx_byte, e.rxb);
        check("mosi_16", mosi_cap[15:0], e.mosi);
        check("mosi_tail_zero", mosi_cap[55:16], 40'h0);
        check("sck_rises", s_rises, 56);
      end
    end
  end

  task automatic push_frame(input logic [23:0] a, input logic [15:0] d, input logic [3:0] o,
                            input logic flag, input logic [7:0] b, input logic [15:0] mosi);
    exp_t x;
    slave_q.push_back({b, 3'b101, flag, o, d, a});
    x.addr = a; x.data = d; x.outsig = o; x.rxv = flag; x.rxb = b; x.mosi = mosi;
    exp_q.push_back(x);
  endtask

  task automatic wait_spiss_high(output int t);
    t = -1;
    for (int i = 0; i < 40; i++) begin
      if (spiss === 1'b1) begin
        t = cyc;
        break;
      end
      @(negedge mclk);
    end
    if (t < 0) check("spiss_rise_timeout", spiss, 1'b1);
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int i = 0; i < 700; i++) begin
      if (frame_done === 1'b1) begin
        t = cyc;
        break;
      end
      @(negedge mclk);
    end
    if (t < 0) check("frame_done_timeout", frame_done, 1'b1);
  endtask

  task automatic offer_tx(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_byte  = b;
    @(negedge mclk);
    tx_valid = 1'b0;
  endtask

  int  t0, t1, t3, t4;
  logic ss_seen;

  initial begin
    run_n = 1'b0; enable = 1'b0; insig = 4'h0; tx_valid = 1'b0; tx_byte = 8'h00;
    repeat (3) @(negedge mclk);
    check("rst_spiss", spiss, 1'b0);
    check("rst_spiclk", spiclk, 1'b0);
    check("rst_spisi", spisi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_addr", addr, 24'h0);
    run_n = 1'b1;
    @(negedge mclk);
    check("tx_ready_after_release", tx_ready, 1'b1);

    // Single frame from a one-cycle enable pulse, no UART traffic.
    insig = 4'h3;
    push_frame(24'h123456, 16'hBEEF, 4'hA, 1'b0, 8'h00, 16'h0003);
    enable = 1'b1;
    @(negedge mclk);
    enable = 1'b0;
    wait_spiss_high(t0);
    check("busy_in_frame", busy, 1'b1);
    check("sck_low_in_setup", spiclk, 1'b0);
    repeat (2) @(negedge mclk);
    check("first_sck_rise", spiclk, 1'b1);
    wait_done(t1);
    check("frame_done_latency", t1 - t0, 450);
    check("spiss_falls_with_done", spiss, 1'b0);
    repeat (20) @(negedge mclk);
    check("idle_after_single", busy, 1'b0);
    check("single_frame_count", done_count, 1);

    // TX byte accepted before the frame; slave returns a UART byte.
    insig = 4'h5;
    offer_tx(8'hC3);
    check("tx_ready_low_after_accept", tx_ready, 1'b0);
    push_frame(24'hABCDEF, 16'h1234, 4'h6, 1'b1, 8'h7E, 16'hC315);
    enable = 1'b1;
    @(negedge mclk);
    enable = 1'b0;
    repeat (200) @(negedge mclk);
    check("tx_ready_low_mid_frame", tx_ready, 1'b0);
    wait_done(t1);
    check("tx_ready_with_done", tx_ready, 1'b1);
    @(negedge mclk);
    check("rx_valid_one_cycle", rx_valid, 1'b0);
    check("rx_byte_held", rx_byte, 8'h7E);
    repeat (20) @(negedge mclk);

    // Continuous run: byte accepted mid-frame rides the next frame; enable drops at bit 10.
    insig = 4'h9;
    push_frame(24'hFFFFFF, 16'h0000, 4'hF, 1'b0, 8'hFF, 16'h0009);
    push_frame(24'h000000, 16'hFFFF, 4'h0, 1'b1, 8'h00, 16'h5A19);
    enable = 1'b1;
    @(negedge mclk);
    wait_spiss_high(t3);
    repeat (100) @(negedge mclk);
    offer_tx(8'h5A);
    check("tx_ready_low_mid_accept", tx_ready, 1'b0);
    wait_done(t1);
    check("rx_byte_held_no_flag", rx_byte, 8'h7E);
    check("tx_ready_still_low", tx_ready, 1'b0);
    @(negedge mclk);
    wait_spiss_high(t4);
    check("continuous_period", t4 - t3, 454);
    repeat (85) @(negedge mclk);
    enable = 1'b0;
    wait_done(t1);
    check("tx_ready_after_carry", tx_ready, 1'b1);
    ss_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge mclk);
      if (spiss === 1'b1) ss_seen = 1'b1;
    end
    check("no_spiss_after_enable_drop", ss_seen, 1'b0);
    check("idle_after_enable_drop", busy, 1'b0);

    // Reset at bit 30 of a frame that carries a pending byte.
    slave_q.push_back(56'hFF_FFFF_FFFF_FFFF);
    offer_tx(8'h99);
    enable = 1'b1;
    @(negedge mclk);
    enable = 1'b0;
    wait_spiss_high(t0);
    repeat (242) @(negedge mclk);
    check("mid_frame_selected", spiss, 1'b1);
    run_n = 1'b0;
    @(negedge mclk);
    check("abort_spiss", spiss, 1'b0);
    check("abort_spiclk", spiclk, 1'b0);
    check("abort_spisi", spisi, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_addr", addr, 24'h0);
    check("abort_rx_byte", rx_byte, 8'h00);
    run_n = 1'b1;
    @(negedge mclk);
    check("tx_ready_after_abort", tx_ready, 1'b1);
    repeat (500) @(negedge mclk);
    check("abort_no_frame_done", done_count, 4);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
